// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around the port arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int MEM_W = 32
);
  logic             if_req;
  logic [MEM_W-1:0] if_addr;
  logic [MEM_W-1:0] if_rdata;
  logic             if_stall;

  logic             d_req;
  logic             d_we;
  logic [MEM_W-1:0] d_addr;
  logic [MEM_W-1:0] d_wdata;
  logic [MEM_W-1:0] d_rdata;
  logic             d_stall;

  logic             m_req;
  logic             m_we;
  logic [MEM_W-1:0] m_addr;
  logic [MEM_W-1:0] m_wdata;
  logic [MEM_W-1:0] m_rdata;
  logic             m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_stall, d_rdata, d_stall, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_stall, d_rdata, d_stall, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// Data wins collisions, but only for MAX_D_STREAK grants in a row while a
// fetch waits. Every grant is preceded by an IDLE cycle; the granted
// access's address/controls are captured so a flushed owner cannot disturb
// an access already on the bus.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int MEM_W        = 32
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [MEM_W-1:0] addr_q, addr_d;
  logic [MEM_W-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [MEM_W-1:0] if_rdata_q, d_rdata_q;
  logic [MEM_W-1:0] if_rdata_c, d_rdata_c;
  logic             i_done, d_done;

  // Next-state: pick an owner from IDLE, release the port on m_ready.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req && (!bus.if_req || streak_q < STREAK_MAX)) begin
          state_d = GRANT_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_d  = GRANT_I;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
        end
      end
      GRANT_I, GRANT_D: if (bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // With no fetch waiting there is nothing to starve, so the streak restarts.
    if (!bus.if_req) streak_d = '0;
  end

  // Completion strobes, bus drive, stall release and read-data forwarding.
  always_comb begin
    i_done      = (state_q == GRANT_I) && bus.m_ready;
    d_done      = (state_q == GRANT_D) && bus.m_ready;
    bus.m_req   = (state_q != IDLE);
    bus.m_we    = (state_q == GRANT_D) && we_q;
    bus.m_addr  = (state_q != IDLE) ? addr_q : '0;
    bus.m_wdata = (state_q == GRANT_D) ? wdata_q : '0;
    bus.if_stall = bus.if_req && !i_done;
    bus.d_stall  = bus.d_req && !d_done;
    if_rdata_c  = i_done ? bus.m_rdata : if_rdata_q;
    d_rdata_c   = (d_done && !we_q) ? bus.m_rdata : d_rdata_q;
    bus.if_rdata = if_rdata_c;
    bus.d_rdata  = d_rdata_c;
  end

  // State, streak, captured access and latched read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_c;
      d_rdata_q  <= d_rdata_c;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_D_STREAK, default 4: consecutive data grants allowed while a fetch is pending.
REQ-002 The block SHALL have parameter MEM_W, default 32: address and data width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port if_req  in  1  fetch-stage read request; the requester holds it and if_addr stable while stalled.
REQ-006 The block SHALL have port if_addr  in  MEM_W  fetch address.
REQ-007 The block SHALL have port if_rdata  out  MEM_W  fetch read data.
REQ-008 The block SHALL have port if_stall  out  1  fetch must hold this cycle.
REQ-009 The block SHALL have port d_req  in  1  MEM-stage request; the requester holds it, d_we, d_addr and d_wdata stable while stalled.
REQ-010 The block SHALL have port d_we  in  1  1 = write, 0 = read.
REQ-011 The block SHALL have port d_addr  in  MEM_W  data address.
REQ-012 The block SHALL have port d_wdata  in  MEM_W  write data.
REQ-013 The block SHALL have port d_rdata  out  MEM_W  data read data.
REQ-014 The block SHALL have port d_stall  out  1  MEM stage must hold this cycle.
REQ-015 The block SHALL have port m_req  out  1  shared memory port request.
REQ-016 The block SHALL have port m_we  out  1  memory write enable.
REQ-017 The block SHALL have port m_addr  out  MEM_W  memory address.
REQ-018 The block SHALL have port m_wdata  out  MEM_W  memory write data.
REQ-019 The block SHALL have port m_rdata  in  MEM_W  memory read data, valid when m_ready=1.
REQ-020 The block SHALL have port m_ready  in  1  memory completes the current access this cycle; latency is 0..N cycles.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, GRANT_I, GRANT_D.
REQ-022 From IDLE, the FSM SHALL go to GRANT_D if d_req=1 and (if_req=0 or streak<MAX_D_STREAK), else to GRANT_I if if_req=1, else stay in IDLE.
REQ-023 From GRANT_x, the FSM SHALL go to IDLE on the cycle m_ready=1, else stay in GRANT_x; back-to-back grants always pass through one IDLE cycle.
REQ-024 m_req SHALL be 1 exactly when the state is GRANT_I or GRANT_D.
REQ-025 In GRANT_I: m_addr=if_addr and m_we=0. In GRANT_D: m_addr=d_addr, m_we=d_we and m_wdata=d_wdata. In IDLE: m_we=0, while m_addr and m_wdata are don't-care.
REQ-026 if_stall SHALL equal if_req AND NOT (state==GRANT_I AND m_ready), combinationally.
REQ-027 d_stall SHALL equal d_req AND NOT (state==GRANT_D AND m_ready), combinationally.
REQ-028 In the GRANT_I completion cycle, if_rdata SHALL equal m_rdata combinationally and be latched; otherwise if_rdata SHALL hold the last latched value. d_rdata SHALL behave the same for GRANT_D read completions only; writes leave d_rdata unchanged.
REQ-029 The streak counter SHALL be ceil(log2(MAX_D_STREAK+1)) bits wide and saturate at MAX_D_STREAK.
REQ-030 The streak counter SHALL increment on each IDLE->GRANT_D transition taken while if_req=1.
REQ-031 The streak counter SHALL clear on each IDLE->GRANT_I transition and on any cycle with if_req=0.
REQ-032 Minimum access latency SHALL be 2 cycles from request to stall release: 1 IDLE cycle plus 1 GRANT cycle with m_ready=1.
REQ-033 If the owner drops its req mid-grant (flush), the access SHALL still run to m_ready; m_addr, m_we and m_wdata are held from registered copies taken at grant; returned data is latched but no stall is released.
REQ-034 m_ready while in IDLE SHALL be ignored.

Reset
REQ-035 On a reset cycle, the state SHALL become IDLE and streak 0; m_req, m_we, if_rdata and d_rdata SHALL be 0 after the edge.
REQ-036 A memory access in flight when reset asserts SHALL be abandoned; m_req SHALL drop the cycle after reset is sampled.
REQ-037 Stall outputs SHALL follow REQ-026/027 during reset, i.e. equal their req inputs.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x10, m_ready=1 every cycle, m_rdata=0x00500093 -> if_stall=1 for 1 cycle, then 0, with if_rdata=0x00500093 and m_addr=0x10.
REQ-039 Collision: if_req=d_req=1 in the same cycle, d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> GRANT_D is taken first (m_we=1, m_wdata=0xDEADBEEF), then IDLE, then GRANT_I; if_stall stays 1 throughout the data access.
REQ-040 Starvation: d_req and if_req held at 1 with m_ready=1 for 12 cycles, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,...
REQ-041 Wait states: m_ready held 0 for 3 GRANT_D cycles on a read of 0x4 returning 0x12345678 -> m_addr is stable for 4 cycles, d_stall falls only in the 4th, and d_rdata=0x12345678.
REQ-042 Flush and reset: if_req drops in GRANT_I -> m_addr is held until m_ready and if_stall=0. Separately, reset asserted in GRANT_D -> m_req=0 and state IDLE on the next cycle, and a stray m_ready is ignored.
